// File: rtl/audio_out_fifo.sv
// Stereo sample FIFO between the output filter and the codec DAC port.
// Playback starts once PRIME pairs are queued; a starved codec counts an underrun and re-primes.
module audio_out_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    parameter int PRIME = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_left,
    input  logic [WIDTH-1:0]         in_right,
    output logic                     in_ready,
    input  logic                     write_ready,
    output logic                     write,
    output logic [WIDTH-1:0]         writedata_left,
    output logic [WIDTH-1:0]         writedata_right,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              underrun_count,
    output logic                     playing
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Samples are opaque two's-complement words; they are stored and replayed untouched.
    logic signed [WIDTH-1:0] mem_left  [DEPTH];
    logic signed [WIDTH-1:0] mem_right [DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [15:0]     underrun_q;
    logic            push, pop, underrun;

    always_comb begin
        in_ready = (count_q < CW'(DEPTH));
        push     = in_valid && in_ready;
        write    = (state_q == RUN) && write_ready && (count_q != '0);
        pop      = write;
        underrun = (state_q == RUN) && write_ready && (count_q == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (count_q >= CW'(PRIME)) state_d = RUN;
            RUN:     if (underrun) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            underrun_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (underrun) underrun_q <= sat_inc16(underrun_q);
        end
    end

    // Storage is data-only and deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_left[wr_ptr_q]  <= in_left;
            mem_right[wr_ptr_q] <= in_right;
        end
    end

    always_comb begin
        writedata_left  = '0;
        writedata_right = '0;
        if (count_q != '0) begin
            writedata_left  = mem_left[rd_ptr_q];
            writedata_right = mem_right[rd_ptr_q];
        end
    end

    assign count          = count_q;
    assign underrun_count = underrun_q;
    assign playing        = (state_q == RUN);

endmodule

// File: tb/tb_audio_out_fifo.sv
// Randomised bench for audio_out_fifo: a queue-based reference model predicts
// occupancy, playback mode and the replayed sample stream.
module tb_audio_out_fifo;

    localparam int W  = 24;
    localparam int D  = 8;
    localparam int P  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_left = '0;
    logic [W-1:0]  in_right = '0;
    logic          write_ready = 1'b0;
    logic          in_ready;
    logic          write;
    logic [W-1:0]  writedata_left;
    logic [W-1:0]  writedata_right;
    logic [CW-1:0] count;
    logic [15:0]   underrun_count;
    logic          playing;

    audio_out_fifo #(.WIDTH(W), .DEPTH(D), .PRIME(P)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_ready       (in_ready),
        .write_ready    (write_ready),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .count          (count),
        .underrun_count (underrun_count),
        .playing        (playing)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of accepted pairs plus a playback flag.
    logic [2*W-1:0] sb[$];
    bit             m_run = 1'b0;
    logic [15:0]    m_under = '0;
    int             n_tests = 0;
    int             n_fail = 0;
    int             n_writes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        int sz;
        bit e_write;
        logic [2*W-1:0] head;
        if (!reset) begin
            sb.delete();
            m_run   = 1'b0;
            m_under = '0;
            check("rst_count", 64'(count), 64'd0);
            check("rst_write", 64'(write), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_playing", 64'(playing), 64'd0);
            check("rst_underrun", 64'(underrun_count), 64'd0);
            check("rst_data", 64'({writedata_left, writedata_right}), 64'd0);
        end else begin
            sz      = sb.size();
            head    = (sz > 0) ? sb[0] : '0;
            e_write = m_run && write_ready && (sz > 0);
            check("count", 64'(count), 64'(sz));
            check("in_ready", 64'(in_ready), 64'(sz < D));
            check("playing", 64'(playing), 64'(m_run));
            check("write", 64'(write), 64'(e_write));
            check("underrun_count", 64'(underrun_count), 64'(m_under));
            check("writedata", 64'({writedata_left, writedata_right}), 64'(head));
            if (write) n_writes++;
            // Predict the effect of the coming rising edge.
            if (e_write) void'(sb.pop_front());
            if (in_valid && sz < D) sb.push_back({in_left, in_right});
            if (m_run && write_ready && sz == 0) begin
                m_run = 1'b0;
                if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
            end else if (!m_run && sz >= P) begin
                m_run = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [W-1:0] first_l, first_r;
        int w0;
        bit sat_ok;

        do_reset();

        // Priming: three pairs are not enough to start playback.
        write_ready = 1'b1;
        first_l = W'($urandom());
        first_r = W'($urandom());
        push_pair(first_l, first_r);
        push_pair(W'($urandom()), W'($urandom()));
        push_pair(W'($urandom()), W'($urandom()));
        check("prime3_write", 64'(write), 64'd0);
        check("prime3_playing", 64'(playing), 64'd0);
        push_pair(24'h000001, 24'hFFFFFF);
        check("prime4_playing_same", 64'(playing), 64'd0);
        step();
        check("prime4_playing_next", 64'(playing), 64'd1);
        check("prime_first_write", 64'(write), 64'd1);
        check("prime_first_data", 64'({writedata_left, writedata_right}), 64'({first_l, first_r}));
        repeat (8) step();
        check("prime_drain_underrun", 64'(underrun_count), 64'd1);

        // Order and pointer wrap with continuous draining.
        do_reset();
        write_ready = 1'b1;
        w0 = n_writes;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1;
            in_left  = W'(i);
            in_right = W'(-i);
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        check("wrap_write_total", 64'(n_writes - w0), 64'd20);

        // Full FIFO: extra pushes are refused, including alongside a pop.
        do_reset();
        write_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_pair(W'($urandom()), W'($urandom()));
        check("full_count", 64'(count), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        push_pair(W'($urandom()), W'($urandom()));
        check("full_ninth_ignored", 64'(count), 64'd8);
        in_valid    = 1'b1;
        write_ready = 1'b1;
        step();
        in_valid    = 1'b0;
        write_ready = 1'b0;
        check("full_pop_count", 64'(count), 64'd7);
        check("full_pop_in_ready", 64'(in_ready), 64'd1);

        // Simultaneous push and pop keep occupancy constant.
        write_ready = 1'b1;
        step();
        step();
        write_ready = 1'b0;
        check("simul_start_count", 64'(count), 64'd5);
        w0 = n_writes;
        in_valid    = 1'b1;
        write_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_left  = W'($urandom());
            in_right = W'($urandom());
            step();
        end
        in_valid    = 1'b0;
        write_ready = 1'b0;
        check("simul_count", 64'(count), 64'd5);
        check("simul_writes", 64'(n_writes - w0), 64'd10);

        // Underrun: drain while the codec keeps asking.
        write_ready = 1'b1;
        repeat (8) step();
        check("under_count", 64'(underrun_count), 64'd1);
        check("under_playing", 64'(playing), 64'd0);
        check("under_write", 64'(write), 64'd0);

        // Saturation: preload the counter to its ceiling while refilling.
        force dut.underrun_q = 16'hFFFF;
        #1;
        release dut.underrun_q;
        #1;
        sat_ok = (underrun_count == 16'hFFFF);
        if (sat_ok) m_under = 16'hFFFF;
        else begin
            $display("[TB] note: counter preload unavailable, saturation step skipped");
            do_reset();
            write_ready = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            push_pair(W'($urandom()), W'($urandom()));
            check("refill_write", 64'(write), 64'd0);
        end
        push_pair(W'($urandom()), W'($urandom()));
        step();
        check("refill_playing", 64'(playing), 64'd1);
        repeat (8) step();
        check("refill_underrun_playing", 64'(playing), 64'd0);
        if (sat_ok) check("sat_underrun", 64'(underrun_count), 64'hFFFF);

        // Asynchronous reset between edges.
        do_reset();
        write_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_pair(W'($urandom()), W'($urandom()));
        check("areset_pre_count", 64'(count), 64'd6);
        write_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("areset_count", 64'(count), 64'd0);
        check("areset_write", 64'(write), 64'd0);
        check("areset_data", 64'({writedata_left, writedata_right}), 64'd0);
        step();
        reset = 1'b1;
        write_ready = 1'b0;
        #1;
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_playing", 64'(playing), 64'd0);

        // Randomised traffic: fill-biased then drain-biased.
        for (int i = 0; i < 600; i++) begin
            if (i < 300) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                write_ready = ($urandom_range(0, 1) != 0);
            end else begin
                in_valid    = ($urandom_range(0, 2) == 0);
                write_ready = ($urandom_range(0, 3) != 0);
            end
            in_left  = W'($urandom());
            in_right = W'($urandom());
            step();
        end
        in_valid    = 1'b0;
        write_ready = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
